// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: serial input, frame config and received-word outputs
// of the UART receive framer.
// Ports: RX_IN, PRESCALE, PAR_EN, PAR_TYP (to receiver);
//        P_DATA, DATA_VALID, PAR_ERR, STP_ERR (from receiver).
interface uart_rx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  RX_IN;
    logic [5:0]            PRESCALE;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_ERR;
    logic                  STP_ERR;

    modport master (
        output RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        input  P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );

    modport slave (
        input  RX_IN, PRESCALE, PAR_EN, PAR_TYP,
        output P_DATA, DATA_VALID, PAR_ERR, STP_ERR
    );
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampling UART receiver; start detect, LSB-first
// deserialisation, optional parity (0 even / 1 odd) and stop check.
// Ports: CLK, RST (async active-low), bus (uart_rx_frame_if.slave).
// Build option: UART_RX_MAJORITY_VOTE_EN -> 2-of-3 vote per bit.
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic            CLK,
    input logic            RST,
    uart_rx_frame_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t                r_state;
    logic [1:0]            r_sync;
    logic [5:0]            r_edge_cnt;
    logic [3:0]            r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [5:0]            r_presc;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_dv;
    logic                  r_pe;
    logic                  r_se;

    logic                  w_rx;
    logic [5:0]            w_half;
    logic                  w_dec;
    logic                  w_last;
    logic                  w_bit;
    logic                  w_par_exp;

    assign w_rx      = r_sync[1];
    assign w_half    = {1'b0, r_presc[5:1]};
    assign w_dec     = (r_edge_cnt == w_half);
    assign w_last    = (r_edge_cnt == 6'(r_presc - 6'd1));
    assign w_par_exp = r_par_typ ? ~^r_shift : ^r_shift;

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic r_s0;
    logic r_s1;

    // The two samples leading up to the decision point.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_s0 <= 1'b1;
            r_s1 <= 1'b1;
        end else begin
            if (r_edge_cnt == 6'(w_half - 6'd2)) r_s0 <= w_rx;
            if (r_edge_cnt == 6'(w_half - 6'd1)) r_s1 <= w_rx;
        end
    end

    assign w_bit = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
`else
    assign w_bit = w_rx;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_sync <= 2'b11;
        else      r_sync <= {r_sync[0], bus.RX_IN};
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_presc    <= '0;
            r_par_en   <= 1'b0;
            r_par_typ  <= 1'b0;
            r_par_bad  <= 1'b0;
            r_p_data   <= '0;
            r_dv       <= 1'b0;
            r_pe       <= 1'b0;
            r_se       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            r_se <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    r_edge_cnt <= '0;
                    r_bit_cnt  <= '0;
                    if (!w_rx) begin
                        r_state   <= S_START;
                        r_presc   <= bus.PRESCALE;
                        r_par_en  <= bus.PAR_EN;
                        r_par_typ <= bus.PAR_TYP;
                        r_par_bad <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_dec && w_bit) begin
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                    end else if (w_last) begin
                        r_state    <= S_DATA;
                        r_edge_cnt <= '0;
                    end else begin
                        r_edge_cnt <= 6'(r_edge_cnt + 6'd1);
                    end
                end
                S_DATA: begin
                    // Shift in at the MSB so the first bit ends at the LSB.
                    if (w_dec) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
                    if (w_last) begin
                        r_edge_cnt <= '0;
                        if (r_bit_cnt == 4'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= 4'(r_bit_cnt + 4'd1);
                        end
                    end else begin
                        r_edge_cnt <= 6'(r_edge_cnt + 6'd1);
                    end
                end
                S_PARITY: begin
                    if (w_dec) r_par_bad <= (w_bit != w_par_exp);
                    if (w_last) begin
                        r_edge_cnt <= '0;
                        r_state    <= S_STOP;
                    end else begin
                        r_edge_cnt <= 6'(r_edge_cnt + 6'd1);
                    end
                end
                S_STOP: begin
                    // Leave at mid stop bit so an immediate start is caught.
                    if (w_dec) begin
                        r_state    <= S_IDLE;
                        r_edge_cnt <= '0;
                        r_se       <= ~w_bit;
                        r_pe       <= r_par_bad;
                        if (w_bit && !r_par_bad) begin
                            r_dv     <= 1'b1;
                            r_p_data <= r_shift;
                        end
                    end else begin
                        r_edge_cnt <= 6'(r_edge_cnt + 6'd1);
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_edge_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.P_DATA     = r_p_data;
    assign bus.DATA_VALID = r_dv;
    assign bus.PAR_ERR    = r_pe;
    assign bus.STP_ERR    = r_se;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against a frame-level model of
// uart_rx_frame, checked every cycle plus literal spot checks.
module tb_uart_rx_frame;
    localparam int DW = 8;
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam bit MV = 1'b1;
`else
    localparam bit MV = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;

    uart_rx_frame_if #(.DATA_WIDTH(DW)) bus ();
    uart_rx_frame #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int          t;
        logic [DW-1:0] d;
        bit          dv;
        bit          pe;
        bit          se;
    } ev_t;

    ev_t           q[$];
    int            dv_cyc[$];
    logic [DW-1:0] m_data = '0;
    int            total = 0;
    int            bad = 0;
    int            last_t0 = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, exp);
        end
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one frame; gl = data bit hit by a 1-cycle inverted pulse
    // at its decision sample, ab = frame bit at which reset is asserted.
    task automatic send(input logic [DW-1:0] d, input int p,
                        input bit pe, input bit pt, input bit pbit,
                        input bit sbit, input int gl, input int ab);
        logic          bits [0:11];
        int            n;
        logic [DW-1:0] ds;
        ev_t           ev;
        bus.PRESCALE = 6'(p);
        bus.PAR_EN   = pe;
        bus.PAR_TYP  = pt;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[1+i] = d[i];
        n = 1 + DW;
        if (pe) begin
            bits[n] = pbit;
            n++;
        end
        bits[n] = sbit;
        n++;
        last_t0 = cyc + 1;
        ds = d;
        if (gl >= 0 && !MV) ds[gl] = ~ds[gl];
        ev.t  = last_t0 + 2 + (1 + DW + int'(pe)) * p + p / 2 + 1;
        ev.d  = ds;
        ev.se = !sbit;
        ev.pe = pe && (pbit != (pt ? ~^ds : ^ds));
        ev.dv = !ev.se && !ev.pe;
        if (ab < 0) q.push_back(ev);
        for (int k = 0; k < n; k++) begin
            for (int c = 0; c < p; c++) begin
                if (k == ab && c == p / 2) begin
                    RST    = 1'b0;
                    m_data = '0;
                    return;
                end
                if (gl >= 0 && k == gl + 1 && c == p / 2 + 1)
                    bus.RX_IN = ~bits[k];
                else
                    bus.RX_IN = bits[k];
                @(posedge CLK);
                #1;
            end
        end
    endtask

    initial begin
        int n0;
        bus.RX_IN    = 1'b1;
        bus.PRESCALE = 6'd16;
        bus.PAR_EN   = 1'b0;
        bus.PAR_TYP  = 1'b0;

        fork
            forever begin
                ev_t           ev;
                bit            e_dv, e_pe, e_se;
                @(negedge CLK);
                e_dv = 0;
                e_pe = 0;
                e_se = 0;
                if (q.size() > 0 && q[0].t == cyc) begin
                    ev   = q.pop_front();
                    e_dv = ev.dv;
                    e_pe = ev.pe;
                    e_se = ev.se;
                    if (ev.dv) m_data = ev.d;
                end
                total++;
                if ({bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR, bus.P_DATA}
                    !== {e_dv, e_pe, e_se, m_data}) begin
                    bad++;
                    $display("FAIL cyc%0d outs got dv=%b pe=%b se=%b d=%h want dv=%b pe=%b se=%b d=%h",
                             cyc, bus.DATA_VALID, bus.PAR_ERR, bus.STP_ERR,
                             bus.P_DATA, e_dv, e_pe, e_se, m_data);
                end
                if (bus.DATA_VALID) dv_cyc.push_back(cyc);
            end
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_outs", 32'({bus.DATA_VALID, bus.PAR_ERR,
                               bus.STP_ERR, bus.P_DATA}), 32'h0);
        RST = 1'b1;
        idle(5);

        send(8'hA5, 16, 1, 0, 0, 1, -1, -1);
        idle(10);
        chk("even_good_data", 32'(bus.P_DATA), 32'hA5);
        chk("even_latency", 32'(dv_cyc[dv_cyc.size()-1] - last_t0), 32'd171);

        send(8'hA5, 16, 1, 0, 1, 1, -1, -1);
        idle(10);
        chk("par_err_hold", 32'(bus.P_DATA), 32'hA5);

        send(8'h00, 8, 1, 1, 1, 1, -1, -1);
        idle(10);
        chk("odd_good_data", 32'(bus.P_DATA), 32'h00);
        chk("odd_latency", 32'(dv_cyc[dv_cyc.size()-1] - last_t0), 32'd87);

        n0 = dv_cyc.size();
        send(8'h3C, 16, 0, 0, 0, 0, -1, -1);
        idle(40);
        chk("stop_err_hold", 32'(bus.P_DATA), 32'h00);
        chk("stop_err_nodv", 32'(dv_cyc.size()), 32'(n0));

        bus.PRESCALE = 6'd16;
        bus.PAR_EN   = 1'b0;
        bus.RX_IN    = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        idle(40);
        chk("glitch_nodv", 32'(dv_cyc.size()), 32'(n0));
        send(8'h5A, 16, 0, 0, 0, 1, -1, -1);
        idle(10);
        chk("after_glitch", 32'(bus.P_DATA), 32'h5A);

        n0 = dv_cyc.size();
        send(8'h3C, 32, 0, 0, 0, 1, -1, -1);
        send(8'hC3, 32, 0, 0, 0, 1, -1, -1);
        idle(40);
        chk("b2b_count", 32'(dv_cyc.size()), 32'(n0 + 2));
        chk("b2b_spacing", 32'(dv_cyc[n0+1] - dv_cyc[n0]), 32'd320);
        chk("b2b_last", 32'(bus.P_DATA), 32'hC3);

        send(8'h99, 16, 0, 0, 0, 1, -1, 4);
        #1;
        chk("rst_mid_outs", 32'({bus.DATA_VALID, bus.PAR_ERR,
                                 bus.STP_ERR, bus.P_DATA}), 32'h0);
        bus.RX_IN = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        idle(40);
        send(8'h81, 16, 0, 0, 0, 1, -1, -1);
        idle(10);
        chk("after_rst", 32'(bus.P_DATA), 32'h81);

        send(8'h0F, 16, 0, 0, 0, 1, 2, -1);
        idle(10);
        chk("bit_glitch", 32'(bus.P_DATA), MV ? 32'h0F : 32'h0B);

        chk("model_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Receive-side UART framer: oversamples the serial line, detects the start bit, deserializes DATA_WIDTH bits LSB-first, checks optional parity and the stop bit, and presents the parallel word with a one-cycle valid strobe. It is the receive counterpart of the Tx path in the UART peripheral and uses the same parity convention: PAR_TYP=0 is even, PAR_TYP=1 is odd. Its outputs feed the UART register/FIFO layer on the microcontroller bus.

## Interface
- DATA_WIDTH, 8: data bits per frame (5..9).
- CLK  input  1  system clock; all logic on posedge.
- RST  input  1  asynchronous, active-low reset.
- RX_IN  input  1  serial line, idle high, asynchronous to CLK.
- PRESCALE  input  6  oversampling ratio. Legal values: 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present.
- PAR_TYP  input  1  0 = even, 1 = odd.
- P_DATA  output  DATA_WIDTH  last correctly received word.
- DATA_VALID  output  1  one-cycle pulse: P_DATA updated.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.

## Operation
- RX_IN passes through a 2-flop synchronizer reset to 1; "rx" below means the synchronized value.
- PRESCALE, PAR_EN and PAR_TYP are latched on start detect and are held constant for the frame.
- Counters:
  - edge_cnt counts 0..PRESCALE-1 within each bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
  - Sample decision is made at edge_cnt == PRESCALE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx==0 -> START, edge_cnt=0.
  - START: at the decision point, if the sample is 1 -> IDLE (glitch; no output). At edge_cnt==PRESCALE-1 -> DATA.
  - DATA: the sample shifts into the shift register LSB-first. After bit DATA_WIDTH-1 completes -> PARITY if PAR_EN, else STOP.
  - PARITY: the sample is compared with ^shift (even) or ~^shift (odd), and the mismatch is stored. At end of bit -> STOP.
  - STOP: at the decision point the frame completes and the FSM goes to IDLE immediately. It does not wait out the stop-bit tail, so a start bit that follows at once is caught.
- Frame completion, registered one cycle after the stop decision:
  - STP_ERR = (stop sample == 0).
  - PAR_ERR = stored mismatch (always 0 when PAR_EN=0).
  - If neither error: DATA_VALID=1 and P_DATA <= shift register.
  - If any error: DATA_VALID=0 and P_DATA holds its previous value.
  - Both errors may pulse in the same cycle.
- Illegal PRESCALE behaviour is undefined, but the FSM must always return to IDLE.

## Timing
- Reset values:
  - P_DATA = 0.
  - DATA_VALID = PAR_ERR = STP_ERR = 0.
  - FSM = IDLE; counters = 0; synchronizer = 1.
- Reset mid-frame aborts the frame silently. After release, the receiver waits for a new falling edge.
- Latency: let T0 be the first CLK edge at which raw RX_IN is sampled low. DATA_VALID asserts at T0 + 2 + (1+DATA_WIDTH+PAR_EN)·PRESCALE + PRESCALE/2 + 1 cycles.
- Output pulses are exactly one cycle. There is no backpressure: the consumer must take P_DATA on the pulse, and P_DATA stays stable until the next good frame.
- Minimum frame-to-frame spacing is zero idle bits.

## Configuration
- UART_RX_MAJORITY_VOTE_EN defined: each bit value is the 2-of-3 majority of rx at edge_cnt = PRESCALE/2-2, PRESCALE/2-1 and PRESCALE/2.
- Not defined: each bit value is the single rx sample at edge_cnt == PRESCALE/2.
- Latency, FSM and ports are identical in both builds.

## Test plan
- Good frame, even parity: PRESCALE=16, PAR_EN=1, PAR_TYP=0, frame 0xA5 with parity 0 and stop 1 -> one DATA_VALID pulse at the computed cycle, P_DATA=0xA5, no error pulses.
- Parity error, then odd parity: same setup, 0xA5 with parity 1 -> PAR_ERR pulse, no DATA_VALID, P_DATA stays 0xA5. Then PRESCALE=8, PAR_TYP=1, 0x00 with parity 1 -> DATA_VALID, P_DATA=0x00.
- Stop error: PAR_EN=0, 0x3C with stop bit 0 -> STP_ERR pulse, no DATA_VALID, P_DATA unchanged.
- Glitch rejection: PRESCALE=16, RX_IN low for 4 cycles then high -> FSM back in IDLE, no output pulses. A valid 0x5A frame sent afterwards is received correctly.
- Back-to-back frames with zero idle: PRESCALE=32, 0x3C then 0xC3 -> two DATA_VALID pulses exactly (10·32) cycles apart, with P_DATA 0x3C then 0xC3.
- Reset mid-frame and majority vote:
  - Assert RST during bit 3 of a frame -> all outputs 0 at once, and the next full frame 0x81 is received correctly.
  - With UART_RX_MAJORITY_VOTE_EN: a 1-cycle inverted pulse at the decision point of a data bit leaves P_DATA correct.
  - Without UART_RX_MAJORITY_VOTE_EN: the same pulse flips that bit.
